// File: rtl/pe_cfg_pkg.sv
// -----------------------------------------------------------------------------
// pe_cfg_pkg
// Shared definitions for the PE configuration loader: the stream word width,
// the loader state encoding and a helper that sizes a chain in whole words.
// -----------------------------------------------------------------------------
package pe_cfg_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } cfg_state_e;

    // Number of WORD_W-bit words needed to carry len chain bits.
    function automatic int cfg_num_words(input int len);
        return (len + WORD_W - 1) / WORD_W;
    endfunction

endpackage

// File: rtl/pe_cfg_rdpack.sv
// -----------------------------------------------------------------------------
// pe_cfg_rdpack
// Packs the bits emerging from the far end of the configuration chain into
// 32-bit readback words, LSB first, and offers them on a valid/ready port.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   shift_i        : a chain shift happens this cycle; sdi_i is captured
//   sdi_i          : chain tail bit (value before the shift edge)
//   last_i         : this shift carries the final chain bit
//   rd_word_o      : packed readback word (unused upper bits zero)
//   rd_valid_o     : rd_word_o is valid
//   rd_ready_i     : consumer accepts rd_word_o
//   stall_o        : the next bit would open a new word while the previous
//                    word is still unaccepted; the loader must not shift
// -----------------------------------------------------------------------------
module pe_cfg_rdpack
    import pe_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_i,
    input  logic              sdi_i,
    input  logic              last_i,
    output logic [WORD_W-1:0] rd_word_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic              stall_o
);

    logic [WORD_W-1:0] acc_q;
    logic [4:0]        rcnt_q;
    logic [WORD_W-1:0] word_q;
    logic              vld_q;
    logic [WORD_W-1:0] packed_s;
    logic              close_s;

    // Accumulator with the incoming bit merged in at the current position.
    assign packed_s = acc_q | (WORD_W'(sdi_i) << rcnt_q);
    // A word closes when it is full or when the chain's last bit arrives.
    assign close_s  = shift_i && ((rcnt_q == 5'd31) || last_i);
    // Only a bit that starts a fresh word can collide with a pending word.
    assign stall_o  = vld_q && !rd_ready_i && (rcnt_q == 5'd0);

    // Bit accumulation, word hand-off and output valid tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            rcnt_q <= 5'd0;
            word_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            if (shift_i) begin
                if (close_s) begin
                    word_q <= packed_s;
                    acc_q  <= '0;
                    rcnt_q <= 5'd0;
                end else begin
                    acc_q  <= packed_s;
                    rcnt_q <= rcnt_q + 5'd1;
                end
            end
            // A capture in the same cycle as a handshake keeps valid high.
            if (close_s) begin
                vld_q <= 1'b1;
            end else if (rd_ready_i) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign rd_word_o  = word_q;
    assign rd_valid_o = vld_q;

endmodule

// File: rtl/pe_cfg_loader.sv
// -----------------------------------------------------------------------------
// pe_cfg_loader
// Bit-serial configuration loader for a CGRA PE tile chain. Accepts 32-bit
// words, shifts exactly CHAIN_LEN bits LSB first into the chain and returns
// the bits that fall out of the far end as packed readback words.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   start, clear_first      : begin a load (optionally clearing the chain)
//   word_in/valid/ready     : configuration word stream
//   rd_word/valid/ready     : readback word stream
//   cfg_shift, cfg_sdo      : chain shift enable and serial data out
//   cfg_sdi                 : serial data from the chain tail
//   config_reset            : chain reset, held CLR_CYCLES cycles in CLEAR
//   busy, done              : activity flag and one-cycle completion pulse
// -----------------------------------------------------------------------------
module pe_cfg_loader
    import pe_cfg_pkg::*;
#(
    parameter int CHAIN_LEN  = 14,
    parameter int CLR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear_first,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic [WORD_W-1:0] rd_word,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              cfg_shift,
    output logic              cfg_sdo,
    input  logic              cfg_sdi,
    output logic              config_reset,
    output logic              busy,
    output logic              done
);

    localparam int NW        = cfg_num_words(CHAIN_LEN);
    localparam int LAST_BITS = CHAIN_LEN - WORD_W * (NW - 1);
    localparam int CW        = $clog2(CHAIN_LEN + 1);
    localparam int WCW       = $clog2(NW + 1);
    localparam int CCW       = $clog2(CLR_CYCLES + 1);

    localparam logic [WCW-1:0] NW_W   = WCW'(NW);
    localparam logic [WCW-1:0] NW_M1  = WCW'(NW - 1);
    localparam logic [CW-1:0]  CL_M1  = CW'(CHAIN_LEN - 1);
    localparam logic [5:0]     LAST_W = 6'(LAST_BITS);
    localparam logic [CCW-1:0] CLR_M1 = CCW'(CLR_CYCLES - 1);

    cfg_state_e        state_q;
    logic              busy_q, done_q, clr_q;
    logic [CCW-1:0]    ccnt_q;

    logic [WORD_W-1:0] ish_q, ish_d;     // input shift register
    logic [5:0]        icnt_q, icnt_d;   // bits left in ish
    logic [WCW-1:0]    wcnt_q, wcnt_d;   // words accepted so far
    logic [CW-1:0]     scnt_q, scnt_d;   // bits shifted so far
    logic              sdo_q, sdo_d;     // last driven serial bit

    logic              stall_s, shift_s, word_ready_s, accept_s, last_bit_s;

    assign shift_s      = (state_q == SHIFT) && (icnt_q != 6'd0) && !stall_s;
    // Request a word when ish is empty or its final bit leaves this cycle,
    // which keeps the serial stream gap-free across word boundaries.
    assign word_ready_s = (state_q == SHIFT) && (wcnt_q != NW_W) &&
                          ((icnt_q == 6'd0) || ((icnt_q == 6'd1) && shift_s));
    assign accept_s     = word_ready_s && word_valid;
    assign last_bit_s   = shift_s && (scnt_q == CL_M1);

    // Next-state logic for the input shift register and its counters.
    always_comb begin
        ish_d  = ish_q;
        icnt_d = icnt_q;
        wcnt_d = wcnt_q;
        scnt_d = scnt_q;
        sdo_d  = sdo_q;
        if (state_q == IDLE) begin
            icnt_d = 6'd0;
            wcnt_d = '0;
            scnt_d = '0;
        end else begin
            if (shift_s) begin
                ish_d  = ish_q >> 1;
                icnt_d = icnt_q - 6'd1;
                scnt_d = scnt_q + CW'(1);
                sdo_d  = ish_q[0];
            end else begin
                sdo_d  = sdo_q;
            end
            // A new word overrides the shift update; its last old bit has
            // already gone out this cycle. The final word is truncated.
            if (accept_s) begin
                ish_d  = word_in;
                icnt_d = (wcnt_q == NW_M1) ? LAST_W : 6'd32;
                wcnt_d = wcnt_q + WCW'(1);
            end else begin
                wcnt_d = wcnt_d;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ish_q  <= '0;
            icnt_q <= 6'd0;
            wcnt_q <= '0;
            scnt_q <= '0;
            sdo_q  <= 1'b0;
        end else begin
            ish_q  <= ish_d;
            icnt_q <= icnt_d;
            wcnt_q <= wcnt_d;
            scnt_q <= scnt_d;
            sdo_q  <= sdo_d;
        end
    end

    // Loader FSM with registered busy, done and config_reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            ccnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        ccnt_q <= '0;
                        if (clear_first) begin
                            state_q <= CLEAR;
                            clr_q   <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                CLEAR: begin
                    if (ccnt_q == CLR_M1) begin
                        state_q <= SHIFT;
                        clr_q   <= 1'b0;
                    end else begin
                        ccnt_q <= ccnt_q + CCW'(1);
                    end
                end
                SHIFT: begin
                    if (last_bit_s) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Only the final readback word can be pending here.
                    if (rd_valid && rd_ready) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    clr_q   <= 1'b0;
                end
            endcase
        end
    end

    pe_cfg_rdpack u_rdpack (
        .clk        (clk),
        .reset      (reset),
        .shift_i    (shift_s),
        .sdi_i      (cfg_sdi),
        .last_i     (last_bit_s),
        .rd_word_o  (rd_word),
        .rd_valid_o (rd_valid),
        .rd_ready_i (rd_ready),
        .stall_o    (stall_s)
    );

    assign word_ready   = word_ready_s;
    assign cfg_shift    = shift_s;
    assign cfg_sdo      = shift_s ? ish_q[0] : sdo_q;
    assign config_reset = clr_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
